// File: rtl/xdma_c2h_desc_issuer.sv
// C2H descriptor-bypass issuer: one descriptor per user request, payload forwarded to the XDMA
// C2H stream, completion tracked with a timeout.
module xdma_c2h_desc_issuer #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [27:0]             req_len,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  output logic                    c2h_tvalid,
  input  logic                    c2h_tready,
  output logic                    c2h_tlast,
  output logic [DATA_WIDTH-1:0]   c2h_tdata,
  output logic [DATA_WIDTH/8-1:0] c2h_tkeep,
  input  logic                    c2h_dsc_byp_ready,
  output logic                    c2h_dsc_byp_load,
  output logic [63:0]             c2h_dsc_byp_src_addr,
  output logic [63:0]             c2h_dsc_byp_dst_addr,
  output logic [27:0]             c2h_dsc_byp_len,
  output logic [15:0]             c2h_dsc_byp_ctl,
  input  logic                    c2h_desc_done,
  output logic                    busy,
  output logic                    len_err,
  output logic                    timeout_err,
  output logic [31:0]             done_cnt
);

  localparam int unsigned KEEP_W     = DATA_WIDTH / 8;
  localparam int unsigned LEN_W      = 28;
  localparam int unsigned BEAT_W     = 24;
  localparam int unsigned BYTE_SHIFT = $clog2(KEEP_W);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] DESC_CTL   = 16'h0013;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic               run_q;
  logic [63:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        ctl_q, ctl_d;
  logic [BEAT_W-1:0]  exp_q, exp_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               len_err_q, len_err_d;
  logic               tmo_err_q, tmo_err_d;
  logic [31:0]        done_cnt_q, done_cnt_d;

  logic [LEN_W:0]     len_round;
  logic [BEAT_W-1:0]  beat_inc;
  logic               last_beat;
  logic [TMO_W-1:0]   tmo_inc;

  assign len_round = {1'b0, req_len} + (LEN_W + 1)'(KEEP_W - 1);
  assign beat_inc  = beat_q + BEAT_W'(1);
  assign last_beat = (beat_inc == exp_q);
  assign tmo_inc   = tmo_q + TMO_W'(1);

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    ctl_d            = ctl_q;
    exp_d            = exp_q;
    beat_d           = beat_q;
    tmo_d            = tmo_q;
    len_err_d        = len_err_q;
    tmo_err_d        = tmo_err_q;
    done_cnt_d       = done_cnt_q;
    req_ready        = 1'b0;
    c2h_dsc_byp_load = 1'b0;
    c2h_tvalid       = 1'b0;
    in_tready        = 1'b0;
    c2h_tlast        = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = run_q;
        if (req_valid && run_q) begin
          if (req_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            len_d   = req_len;
            ctl_d   = DESC_CTL;
            exp_d   = BEAT_W'(len_round >> BYTE_SHIFT);
            beat_d  = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        c2h_dsc_byp_load = c2h_dsc_byp_ready;
        if (c2h_dsc_byp_ready) state_d = STREAM;
      end
      STREAM: begin
        c2h_tvalid = in_tvalid;
        in_tready  = c2h_tready;
        // The final expected beat is closed off even if upstream never marks it
        c2h_tlast  = in_tlast | last_beat;
        if (in_tvalid && c2h_tready) begin
          beat_d = beat_inc;
          if (in_tlast || last_beat) begin
            if (!(in_tlast && last_beat)) len_err_d = 1'b1;
            tmo_d   = '0;
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (c2h_desc_done) begin
          done_cnt_d = done_cnt_q + 32'd1;
          state_d    = IDLE;
        end else if (tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      ctl_q      <= '0;
      exp_q      <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      len_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ctl_q      <= ctl_d;
      exp_q      <= exp_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      len_err_q  <= len_err_d;
      tmo_err_q  <= tmo_err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign c2h_tdata            = in_tdata;
  assign c2h_tkeep            = in_tkeep;
  assign c2h_dsc_byp_src_addr = '0;
  assign c2h_dsc_byp_dst_addr = addr_q;
  assign c2h_dsc_byp_len      = len_q;
  assign c2h_dsc_byp_ctl      = ctl_q;
  assign busy                 = (state_q != IDLE);
  assign len_err              = len_err_q;
  assign timeout_err          = tmo_err_q;
  assign done_cnt             = done_cnt_q;

endmodule

// File: tb/tb_xdma_c2h_desc_issuer.sv
// Directed bench for xdma_c2h_desc_issuer: a table of whole transactions plus hand-written
// sequences for zero length, descriptor back-pressure and reset during streaming.
module tb_xdma_c2h_desc_issuer;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr = '0;
  logic [27:0]   req_len = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '1;
  logic          c2h_tvalid;
  logic          c2h_tready = 1'b1;
  logic          c2h_tlast;
  logic [DW-1:0] c2h_tdata;
  logic [KW-1:0] c2h_tkeep;
  logic          c2h_dsc_byp_ready = 1'b1;
  logic          c2h_dsc_byp_load;
  logic [63:0]   c2h_dsc_byp_src_addr;
  logic [63:0]   c2h_dsc_byp_dst_addr;
  logic [27:0]   c2h_dsc_byp_len;
  logic [15:0]   c2h_dsc_byp_ctl;
  logic          c2h_desc_done = 1'b0;
  logic          busy;
  logic          len_err;
  logic          timeout_err;
  logic [31:0]   done_cnt;

  int checks = 0;
  int errors = 0;

  xdma_c2h_desc_issuer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready), .c2h_tlast(c2h_tlast),
    .c2h_tdata(c2h_tdata), .c2h_tkeep(c2h_tkeep),
    .c2h_dsc_byp_ready(c2h_dsc_byp_ready), .c2h_dsc_byp_load(c2h_dsc_byp_load),
    .c2h_dsc_byp_src_addr(c2h_dsc_byp_src_addr), .c2h_dsc_byp_dst_addr(c2h_dsc_byp_dst_addr),
    .c2h_dsc_byp_len(c2h_dsc_byp_len), .c2h_dsc_byp_ctl(c2h_dsc_byp_ctl),
    .c2h_desc_done(c2h_desc_done),
    .busy(busy), .len_err(len_err), .timeout_err(timeout_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // One transaction: upstream offers 'avail' beats, tlast on beat 'tlast_at' (0 = never),
  // done pulsed 'done_dly' cycles after the closing beat (0 = never).
  typedef struct {
    logic [63:0] addr;
    logic [27:0] len;
    int          avail;
    int          tlast_at;
    int          done_dly;
    int          exp_beats;
    int          exp_wait;
    logic        exp_len_err;
    logic        exp_tmo;
    logic [31:0] exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int idx);
    return {8{32'hA5A5_0000 ^ 32'(idx)}};
  endfunction

  task automatic idle_inputs();
    req_valid         = 1'b0;
    req_addr          = '0;
    req_len           = '0;
    in_tvalid         = 1'b0;
    in_tlast          = 1'b0;
    in_tdata          = '0;
    c2h_tready        = 1'b1;
    c2h_dsc_byp_ready = 1'b1;
    c2h_desc_done     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int cyc = 0, c_l = -1, src_idx = 0, loads = 0, load_cyc = -1, beats = 0;
    int wait_cnt = 0, leak = 0, bad_data = 0;
    logic last_tlast = 1'b0;
    logic [63:0] dst_seen = '0, src_seen = '1;
    logic [27:0] len_seen = '0;
    logic [15:0] ctl_seen = '0;
    bit finished = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_len   = v.len;
    #1;
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    while (cyc < 100) begin
      @(negedge clk);
      req_valid     = 1'b0;
      in_tvalid     = (src_idx < v.avail);
      in_tlast      = (v.tlast_at != 0) && (src_idx + 1 == v.tlast_at);
      in_tdata      = pattern(src_idx);
      c2h_desc_done = (c_l >= 0) && (v.done_dly != 0) && (cyc == c_l + v.done_dly);
      #1;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (c2h_dsc_byp_load) begin
        loads++;
        if (loads == 1) begin
          load_cyc = cyc;
          dst_seen = c2h_dsc_byp_dst_addr;
          src_seen = c2h_dsc_byp_src_addr;
          len_seen = c2h_dsc_byp_len;
          ctl_seen = c2h_dsc_byp_ctl;
        end
      end
      if (c2h_tvalid && c2h_tready) begin
        beats++;
        if (c2h_tdata !== pattern(src_idx)) bad_data++;
        last_tlast = c2h_tlast;
        if (c2h_tlast && c_l < 0) c_l = cyc;
      end
      if (in_tvalid && in_tready) src_idx++;
      if (c_l >= 0 && cyc > c_l) begin
        wait_cnt++;
        if (in_tready || c2h_tvalid) leak++;
      end
      cyc++;
    end
    c2h_desc_done = 1'b0;
    in_tvalid     = 1'b0;
    in_tlast      = 1'b0;
    check({tag, " completed"}, 64'(finished), 64'd1);
    check({tag, " loads"}, 64'(loads), 64'd1);
    check({tag, " load_latency"}, 64'(load_cyc), 64'd0);
    check({tag, " dst_addr"}, dst_seen, v.addr);
    check({tag, " src_addr"}, src_seen, 64'd0);
    check({tag, " desc_len"}, 64'(len_seen), 64'(v.len));
    check({tag, " desc_ctl"}, 64'(ctl_seen), 64'h13);
    check({tag, " beats"}, 64'(beats), 64'(v.exp_beats));
    check({tag, " last_tlast"}, 64'(last_tlast), 64'd1);
    check({tag, " data"}, 64'(bad_data), 64'd0);
    check({tag, " wait_cycles"}, 64'(wait_cnt), 64'(v.exp_wait));
    check({tag, " wait_leak"}, 64'(leak), 64'd0);
    check({tag, " len_err"}, 64'(len_err), 64'(v.exp_len_err));
    check({tag, " timeout_err"}, 64'(timeout_err), 64'(v.exp_tmo));
    check({tag, " done_cnt"}, 64'(done_cnt), 64'(v.exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 64'(req_ready), 64'd0);
    check({tag, " load"}, 64'(c2h_dsc_byp_load), 64'd0);
    check({tag, " c2h_tvalid"}, 64'(c2h_tvalid), 64'd0);
    check({tag, " in_tready"}, 64'(in_tready), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " len_err"}, 64'(len_err), 64'd0);
    check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd0);
    check({tag, " dst_addr"}, c2h_dsc_byp_dst_addr, 64'd0);
    check({tag, " desc_len"}, 64'(c2h_dsc_byp_len), 64'd0);
  endtask

  initial begin
    int viol;
    vec_t post;
    //          addr        len     av tl dd  beats wait lerr tmo done
    vecs[0] = '{64'h1000, 28'd64,  2, 2, 5,  2,    5,   1'b0, 1'b0, 32'd1};
    vecs[1] = '{64'h2000, 28'd40,  2, 1, 3,  1,    3,   1'b1, 1'b0, 32'd1};
    vecs[2] = '{64'h3000, 28'd32,  3, 0, 2,  1,    2,   1'b1, 1'b0, 32'd1};
    vecs[3] = '{64'h4000, 28'd100, 4, 4, 1,  4,    1,   1'b0, 1'b0, 32'd1};
    vecs[4] = '{64'h5000, 28'd33,  5, 3, 4,  2,    4,   1'b1, 1'b0, 32'd1};
    vecs[5] = '{64'h6000, 28'd64,  2, 2, 0,  2,    16,  1'b0, 1'b1, 32'd0};
    vecs[6] = '{64'h7000, 28'd1,   1, 1, 15, 1,    15,  1'b0, 1'b0, 32'd1};
    vecs[7] = '{64'h8000, 28'd96,  3, 3, 16, 3,    16,  1'b0, 1'b0, 32'd1};

    idle_inputs();
    #12;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_txn($sformatf("v%0d", i), vecs[i]);
    end

    // Zero-length request: accepted, flagged, no descriptor
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_len   = '0;
    req_addr  = 64'hDEAD;
    #1;
    check("len0 req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("len0 len_err", 64'(len_err), 64'd1);
    check("len0 busy", 64'(busy), 64'd0);
    check("len0 req_ready_after", 64'(req_ready), 64'd1);
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (c2h_dsc_byp_load || busy) viol++;
    end
    check("len0 no_desc", 64'(viol), 64'd0);

    // Descriptor back-pressure: ready low for 10 LOAD cycles
    do_reset();
    c2h_dsc_byp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'hB000;
    req_len   = 28'd64;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      in_tvalid = 1'b1;
      in_tdata  = pattern(0);
      #1;
      if (c2h_dsc_byp_load || c2h_tvalid || in_tready || !busy) viol++;
    end
    check("stall held", 64'(viol), 64'd0);
    @(negedge clk);
    c2h_dsc_byp_ready = 1'b1;
    #1;
    check("stall load_on_ready", 64'(c2h_dsc_byp_load), 64'd1);
    check("stall dst_addr", c2h_dsc_byp_dst_addr, 64'hB000);
    @(negedge clk);
    #1;
    check("stall stream_start", 64'(c2h_tvalid), 64'd1);

    // Reset during STREAM, then a fresh 32-byte request
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h9000;
    req_len   = 28'd128;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    in_tvalid = 1'b1;
    in_tdata  = pattern(0);
    #1;
    check("rst_mid streaming", 64'(c2h_tvalid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (c2h_dsc_byp_load || c2h_tvalid || in_tready || busy) viol++;
    end
    check("rst_mid abandoned", 64'(viol), 64'd0);
    in_tvalid = 1'b0;
    post = '{64'hA000, 28'd32, 1, 1, 4, 1, 4, 1'b0, 1'b0, 32'd1};
    run_txn("post_rst", post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
